// File: rtl/bubble_host_pkg.sv
// Shared state encodings and default widths for the bubble host sequencer.
package bubble_host_pkg;

  localparam int DEF_CNT_W = 24;
  localparam int DEF_REP_W = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_END
  } seq_state_t;

  typedef enum logic [1:0] {
    P_OFF,
    P_WAIT,
    P_LOW,
    P_HIGH
  } rep_phase_t;

endpackage

// File: rtl/bhs_pulse_gen.sv
// Replicator enable generator: initial delay, then repeating low/high pulses on nrep.
module bhs_pulse_gen
  import bubble_host_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             halt,
  input  logic             allow,
  input  logic [CNT_W-1:0] rep_dly,
  input  logic [CNT_W-1:0] rep_low,
  input  logic [CNT_W-1:0] rep_period,
  output logic             nrep,
  output logic             fall
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  rep_phase_t       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nrep_q, nrep_d;
  logic [CNT_W-1:0] gap;

  // A low time that fills the whole period still leaves one high cycle.
  assign gap = (rep_period > rep_low) ? rep_period - rep_low : ONE;

  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    nrep_d  = nrep_q;
    fall    = 1'b0;
    if (load) begin
      phase_d = P_WAIT;
      cnt_d   = rep_dly;
      nrep_d  = 1'b1;
    end else if (halt) begin
      phase_d = P_OFF;
      cnt_d   = '0;
      nrep_d  = 1'b1;
    end else begin
      unique case (phase_q)
        P_WAIT, P_HIGH: begin
          if (cnt_q <= ONE) begin
            if (allow && (rep_low != '0)) begin
              phase_d = P_LOW;
              cnt_d   = rep_low;
              nrep_d  = 1'b0;
              fall    = 1'b1;
            end else begin
              phase_d = P_OFF;
              nrep_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        P_LOW: begin
          if (cnt_q <= ONE) begin
            phase_d = P_HIGH;
            cnt_d   = gap;
            nrep_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= P_OFF;
      cnt_q   <= '0;
      nrep_q  <= 1'b1;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      nrep_q  <= nrep_d;
    end
  end

  assign nrep = nrep_q;

endmodule

// File: rtl/bubble_host_sequencer.sv
// Bubble memory host sequencer: lead delay, nBSEN shift window and replicator pulses.
// Bootloop mode (MODE/STOP) is compiled in only when BHS_BOOTLOOP_EN is defined.
module bubble_host_sequencer
  import bubble_host_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             MCLK,
  input  logic             MRST,
  input  logic             START,
  input  logic             MODE,
  input  logic             STOP,
  input  logic [CNT_W-1:0] LEAD_CYC,
  input  logic [CNT_W-1:0] BSEN_LEN,
  input  logic [CNT_W-1:0] REP_DLY,
  input  logic [CNT_W-1:0] REP_LOW,
  input  logic [CNT_W-1:0] REP_PERIOD,
  input  logic [REP_W-1:0] REP_CNT,
  output logic             nBSEN,
  output logic             nREPEN,
  output logic             BUSY,
  output logic             DONE,
  output logic [REP_W-1:0] PULSE_IDX
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] bsen_len_q, rep_dly_q, rep_low_q, rep_period_q;
  logic [REP_W-1:0] rep_cnt_q;
  logic             accept, boot, stop_hit, expire;
  logic             gen_load, gen_halt, gen_allow, gen_fall;

  assign accept = (state_q == S_IDLE) && START;

`ifdef BHS_BOOTLOOP_EN
  logic mode_q;

  always_ff @(posedge MCLK or posedge MRST) begin
    if (MRST)        mode_q <= 1'b0;
    else if (accept) mode_q <= MODE;
  end

  assign boot     = mode_q;
  assign stop_hit = mode_q && STOP;
`else
  logic unused_mode_stop;
  assign unused_mode_stop = MODE ^ STOP;
  assign boot     = 1'b0;
  assign stop_hit = 1'b0;
`endif

  // cnt_q counts the lead delay in LEAD and the remaining window in SHIFT.
  assign expire = !boot && (cnt_q <= ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_LEAD;
          cnt_d   = LEAD_CYC;
        end
      end
      S_LEAD: begin
        if (cnt_q == '0) begin
          state_d = S_SHIFT;
          cnt_d   = bsen_len_q;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_SHIFT: begin
        if (expire || stop_hit) state_d = S_END;
        else if (!boot)         cnt_d   = cnt_q - ONE;
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the latched configuration is reset as well so no X reaches the counters after reset.
  always_ff @(posedge MCLK or posedge MRST) begin
    if (MRST) begin
      bsen_len_q   <= '0;
      rep_dly_q    <= '0;
      rep_low_q    <= '0;
      rep_period_q <= '0;
      rep_cnt_q    <= '0;
    end else if (accept) begin
      bsen_len_q   <= BSEN_LEN;
      rep_dly_q    <= REP_DLY;
      rep_low_q    <= REP_LOW;
      rep_period_q <= REP_PERIOD;
      rep_cnt_q    <= REP_CNT;
    end
  end

  always_ff @(posedge MCLK or posedge MRST) begin
    if (MRST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      nBSEN     <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PULSE_IDX <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nBSEN   <= (state_d != S_SHIFT);
      BUSY    <= (state_d != S_IDLE);
      DONE    <= (state_d == S_END);
      if (accept)                             PULSE_IDX <= '0;
      else if (gen_fall && (PULSE_IDX != '1)) PULSE_IDX <= PULSE_IDX + REP_W'(1);
    end
  end

  // Leaving SHIFT halts the generator on the same edge, truncating any pulse.
  assign gen_load  = (state_q == S_LEAD) && (cnt_q == '0);
  assign gen_halt  = (state_d != S_SHIFT);
  assign gen_allow = boot || (PULSE_IDX < rep_cnt_q);

  bhs_pulse_gen #(
    .CNT_W(CNT_W)
  ) u_pulse_gen (
    .clk       (MCLK),
    .rst       (MRST),
    .load      (gen_load),
    .halt      (gen_halt),
    .allow     (gen_allow),
    .rep_dly   (rep_dly_q),
    .rep_low   (rep_low_q),
    .rep_period(rep_period_q),
    .nrep      (nREPEN),
    .fall      (gen_fall)
  );

endmodule
